// File: rtl/logic_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : logic_issue_stage
// Purpose  : Issue stage in front of the 32-bit logical unit. It accepts a
//            decoded XOR/OR/AND instruction in register or immediate form,
//            selects operand B and maps funct3 to the unit's 2-bit select.
//            A, B and L_sel are presented through a registered valid/ready
//            interface. A 2-entry skid buffer (output register plus skid
//            register) keeps full throughput while in_ready_o stays a
//            function of registered state. Illegal funct3 encodings are
//            consumed, dropped and flagged with a one-cycle pulse.
// Ports    : clk_i, rst_n_i (sync, active-low), flush_i
//            in_valid_i / in_ready_o, in_funct3_i, in_rs1_val_i,
//            in_rs2_val_i, in_imm_i, in_use_imm_i, in_rd_i
//            out_valid_o / out_ready_i, out_L_sel_o, out_A_o, out_B_o,
//            out_rd_o, illegal_op_o
// Macro    : LOGIC_ISSUE_NOT_FOLD_EN - when defined, xori with an all-ones
//            immediate issues NOT (01) with B = 0 instead of XOR with
//            B = all ones. The logical unit produces the same result.
// Revision : 1.0 - initial release
// ============================================================================
module logic_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      in_funct3_i,
  input  logic [XLEN-1:0] in_rs1_val_i,
  input  logic [XLEN-1:0] in_rs2_val_i,
  input  logic [XLEN-1:0] in_imm_i,
  input  logic            in_use_imm_i,
  input  logic [4:0]      in_rd_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [1:0]      out_L_sel_o,
  output logic [XLEN-1:0] out_A_o,
  output logic [XLEN-1:0] out_B_o,
  output logic [4:0]      out_rd_o,
  output logic            illegal_op_o
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Output entry (what the logical unit sees) and the skid entry behind it.
  logic [1:0]      sel_q,      skid_sel_q;
  logic [XLEN-1:0] a_q,        skid_a_q;
  logic [XLEN-1:0] b_q,        skid_b_q;
  logic [4:0]      rd_q,       skid_rd_q;
  logic            illegal_q,  illegal_d;

  // Decoded form of the incoming instruction.
  logic            legal;
  logic [1:0]      new_sel;
  logic [XLEN-1:0] new_b;

  logic push, pop, consume;
  logic load_out_new, load_out_skid, load_skid;

  always_comb begin
    legal   = 1'b1;
    new_sel = 2'b00;
    new_b   = in_use_imm_i ? in_imm_i : in_rs2_val_i;
    case (in_funct3_i)
      3'b100:  new_sel = 2'b00;
      3'b110:  new_sel = 2'b10;
      3'b111:  new_sel = 2'b11;
      default: legal   = 1'b0;
    endcase
`ifdef LOGIC_ISSUE_NOT_FOLD_EN
    // xori rd, rs1, -1 is a bitwise NOT of rs1.
    if (in_funct3_i == 3'b100 && in_use_imm_i && (&in_imm_i)) begin
      new_sel = 2'b01;
      new_b   = '0;
    end
`endif
  end

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready_o  = (state_q != S_FULL) & rst_n_i;
  assign out_valid_o = (state_q != S_EMPTY);

  assign consume   = in_valid_i & in_ready_o & ~flush_i;
  assign push      = consume & legal;
  assign illegal_d = consume & ~legal;
  assign pop       = out_valid_o & out_ready_i;

  always_comb begin
    state_d       = state_q;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush_i) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (push) begin
            state_d      = S_ONE;
            load_out_new = 1'b1;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            load_out_new = 1'b1;
          end else if (push) begin
            state_d   = S_FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          // in_ready is low here, so no push can arrive.
          if (pop) begin
            state_d       = S_ONE;
            load_out_skid = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_EMPTY;
      sel_q      <= 2'b00;
      a_q        <= '0;
      b_q        <= '0;
      rd_q       <= '0;
      skid_sel_q <= 2'b00;
      skid_a_q   <= '0;
      skid_b_q   <= '0;
      skid_rd_q  <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (load_out_new) begin
        sel_q <= new_sel;
        a_q   <= in_rs1_val_i;
        b_q   <= new_b;
        rd_q  <= in_rd_i;
      end else if (load_out_skid) begin
        sel_q <= skid_sel_q;
        a_q   <= skid_a_q;
        b_q   <= skid_b_q;
        rd_q  <= skid_rd_q;
      end
      if (load_skid) begin
        skid_sel_q <= new_sel;
        skid_a_q   <= in_rs1_val_i;
        skid_b_q   <= new_b;
        skid_rd_q  <= in_rd_i;
      end
    end
  end

  assign out_L_sel_o  = sel_q;
  assign out_A_o      = a_q;
  assign out_B_o      = b_q;
  assign out_rd_o     = rd_q;
  assign illegal_op_o = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_issue_stage
// Purpose  : Self-checking bench for logic_issue_stage. A queue-based model
//            of the two-entry FIFO is compared against the DUT on every
//            falling edge; directed sequences add literal expectations.
// Macro    : LOGIC_ISSUE_NOT_FOLD_EN selects the expected xori -1 form.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_issue_stage;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      in_funct3 = 3'b100;
  logic [XLEN-1:0] in_rs1 = '0;
  logic [XLEN-1:0] in_rs2 = '0;
  logic [XLEN-1:0] in_imm = '0;
  logic            in_use_imm = 1'b0;
  logic [4:0]      in_rd = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [1:0]      out_sel;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [4:0]      out_rd;
  logic            illegal_op;

  always #5 clk = ~clk;

  logic_issue_stage #(.XLEN(XLEN)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_funct3_i  (in_funct3),
    .in_rs1_val_i (in_rs1),
    .in_rs2_val_i (in_rs2),
    .in_imm_i     (in_imm),
    .in_use_imm_i (in_use_imm),
    .in_rd_i      (in_rd),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_L_sel_o  (out_sel),
    .out_A_o      (out_a),
    .out_B_o      (out_b),
    .out_rd_o     (out_rd),
    .illegal_op_o (illegal_op)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [1:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } ent_t;

  ent_t q[$];
  logic exp_ill     = 1'b0;
  bit   reset_clean = 1'b1;   // no entry loaded since the last reset

  // What the logical unit must be asked to do for one instruction.
  function automatic ent_t make_entry(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] rs2, input logic [31:0] imm,
                                      input logic use_imm, input logic [4:0] rd);
    ent_t e;
    e.a  = a;
    e.rd = rd;
    e.b  = use_imm ? imm : rs2;
    e.sel = (f3 == 3'b110) ? 2'b10 : (f3 == 3'b111) ? 2'b11 : 2'b00;
`ifdef LOGIC_ISSUE_NOT_FOLD_EN
    if (f3 == 3'b100 && use_imm && imm == 32'hFFFF_FFFF) begin
      e.sel = 2'b01;
      e.b   = 32'h0;
    end
`endif
    return e;
  endfunction

  always @(posedge clk) begin
    bit accept;
    bit legal;
    accept = in_valid && (q.size() < 2);
    legal  = (in_funct3 == 3'b100) || (in_funct3 == 3'b110) || (in_funct3 == 3'b111);
    if (!rst_n) begin
      q.delete();
      exp_ill     = 1'b0;
      reset_clean = 1'b1;
    end else if (flush) begin
      q.delete();
      exp_ill = 1'b0;
    end else begin
      exp_ill = accept && !legal;
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (accept && legal) begin
        q.push_back(make_entry(in_funct3, in_rs1, in_rs2, in_imm, in_use_imm, in_rd));
        reset_clean = 1'b0;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    check("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
    check("in_ready", {31'b0, in_ready}, {31'b0, (q.size() < 2) && rst_n});
    check("illegal_op", {31'b0, illegal_op}, {31'b0, exp_ill});
    if (q.size() > 0) begin
      check("L_sel", {30'b0, out_sel}, {30'b0, q[0].sel});
      check("A", out_a, q[0].a);
      check("B", out_b, q[0].b);
      check("rd", {27'b0, out_rd}, {27'b0, q[0].rd});
    end else if (reset_clean) begin
      check("reset_outs", {out_sel, out_rd, out_a[24:0]} | out_b, 32'h0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b2, input logic [31:0] imm,
                       input logic ui, input logic [4:0] rd);
    in_valid   = v;
    in_funct3  = f3;
    in_rs1     = a;
    in_rs2     = b2;
    in_imm     = imm;
    in_use_imm = ui;
    in_rd      = rd;
  endtask

  initial begin
    // Reset then idle
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("lit_rst_valid", {31'b0, out_valid}, 32'h0);
    check("lit_rst_ready", {31'b0, in_ready}, 32'h1);
    check("lit_rst_A", out_a, 32'h0);
    check("lit_rst_B", out_b, 32'h0);
    check("lit_rst_sel_rd", {25'b0, out_sel, out_rd}, 32'h0);

    // Back-to-back OR then ANDI
    out_ready = 1'b1;
    drive(1, 3'b110, 32'hF0F0_0000, 32'h0000_0F0F, 32'h1234_5678, 0, 5'd3);
    tick();
    check("lit_b2b_or_sel", {30'b0, out_sel}, 32'h2);
    check("lit_b2b_or_B", out_b, 32'h0000_0F0F);
    check("lit_b2b_or_A", out_a, 32'hF0F0_0000);
    drive(1, 3'b111, 32'hAAAA_5555, 32'hDEAD_BEEF, 32'h0000_00FF, 1, 5'd4);
    tick();
    check("lit_b2b_and_valid", {31'b0, out_valid}, 32'h1);
    check("lit_b2b_and_sel", {30'b0, out_sel}, 32'h3);
    check("lit_b2b_and_B", out_b, 32'h0000_00FF);
    in_valid = 1'b0;
    tick();
    check("lit_b2b_drain", {31'b0, out_valid}, 32'h0);

    // Backpressure: three offered, two held
    out_ready = 1'b0;
    drive(1, 3'b100, 32'h1111_1111, 32'h0000_0001, 32'h0, 0, 5'd1);
    tick();
    check("lit_bp_ready1", {31'b0, in_ready}, 32'h1);
    drive(1, 3'b110, 32'h2222_2222, 32'h0000_0002, 32'h0, 0, 5'd2);
    tick();
    check("lit_bp_ready2", {31'b0, in_ready}, 32'h0);
    check("lit_bp_hold_A", out_a, 32'h1111_1111);
    drive(1, 3'b111, 32'h3333_3333, 32'h0000_0003, 32'h0, 0, 5'd3);
    tick();
    check("lit_bp_stable_A", out_a, 32'h1111_1111);
    check("lit_bp_stable_rd", {27'b0, out_rd}, 32'h1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("lit_bp_second_A", out_a, 32'h2222_2222);
    check("lit_bp_second_sel", {30'b0, out_sel}, 32'h2);
    check("lit_bp_ready_back", {31'b0, in_ready}, 32'h1);
    tick();
    check("lit_bp_empty", {31'b0, out_valid}, 32'h0);

    // Illegal funct3 then a normal XOR
    drive(1, 3'b000, 32'h5555_5555, 32'h1, 32'h0, 0, 5'd7);
    tick();
    check("lit_ill_novalid", {31'b0, out_valid}, 32'h0);
    check("lit_ill_pulse", {31'b0, illegal_op}, 32'h1);
    drive(1, 3'b100, 32'h0F0F_0F0F, 32'hFFFF_0000, 32'h0, 0, 5'd8);
    tick();
    check("lit_ill_pulse_end", {31'b0, illegal_op}, 32'h0);
    check("lit_ill_xor_valid", {31'b0, out_valid}, 32'h1);
    check("lit_ill_xor_sel", {30'b0, out_sel}, 32'h0);
    in_valid = 1'b0;
    tick();

    // xori rd, rs1, -1
    drive(1, 3'b100, 32'h1234_5678, 32'h0BAD_F00D, 32'hFFFF_FFFF, 1, 5'd9);
    tick();
    in_valid = 1'b0;
`ifdef LOGIC_ISSUE_NOT_FOLD_EN
    check("lit_not_sel", {30'b0, out_sel}, 32'h1);
    check("lit_not_B", out_b, 32'h0);
`else
    check("lit_not_sel", {30'b0, out_sel}, 32'h0);
    check("lit_not_B", out_b, 32'hFFFF_FFFF);
`endif
    check("lit_not_A", out_a, 32'h1234_5678);
    tick();

    // Flush while FULL
    out_ready = 1'b0;
    drive(1, 3'b110, 32'hAAAA_0001, 32'h1, 32'h0, 0, 5'd10);
    tick();
    drive(1, 3'b111, 32'hAAAA_0002, 32'h2, 32'h0, 0, 5'd11);
    tick();
    check("lit_fl_full", {31'b0, in_ready}, 32'h0);
    flush = 1'b1;
    drive(1, 3'b000, 32'hAAAA_0003, 32'h3, 32'h0, 0, 5'd12);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("lit_fl_valid", {31'b0, out_valid}, 32'h0);
    check("lit_fl_ready", {31'b0, in_ready}, 32'h1);
    check("lit_fl_noill", {31'b0, illegal_op}, 32'h0);
    out_ready = 1'b1;
    tick();
    check("lit_fl_nostale", {31'b0, out_valid}, 32'h0);

    // Reset while FULL
    out_ready = 1'b0;
    drive(1, 3'b100, 32'hBBBB_0001, 32'h1, 32'h0, 0, 5'd13);
    tick();
    drive(1, 3'b100, 32'hBBBB_0002, 32'h2, 32'h0, 0, 5'd14);
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    check("lit_rs_valid", {31'b0, out_valid}, 32'h0);
    check("lit_rs_A", out_a, 32'h0);
    rst_n = 1'b1;
    #1;
    check("lit_rs_ready", {31'b0, in_ready}, 32'h1);
    out_ready = 1'b1;
    tick();
    check("lit_rs_nostale", {31'b0, out_valid}, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [2:0]  f3;
      logic [31:0] imm;
      f3  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                        : ((($urandom_range(0, 2)) == 0) ? 3'b100 :
                                           (($urandom_range(0, 1)) == 0) ? 3'b110 : 3'b111);
      imm = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
      drive(1'($urandom_range(0, 3) != 0), f3, $urandom, $urandom, imm,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n    = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
